// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester a grant goes to
//   starve_t    : starvation counter width (limit range 1..15)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef logic [3:0] starve_t;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and the
// MEM-stage data port. One transaction at a time over a req/ack interface.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no access outstanding, arbitration evaluated every cycle
// BUSY_I | fetch issued, m_req held until m_ack
// BUSY_D | load/store issued, m_req held until m_ack
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   if_req/if_addr/if_flush    fetch request side
//   if_rdata/if_valid          fetch response (registered, 1-cycle pulse)
//   mem_read_in/mem_write_in   MEM-stage data request (level)
//   d_addr/d_wdata             data address / store data
//   d_rdata/d_valid            data response (registered, 1-cycle pulse)
//   stall_if/stall_mem         pipeline freeze (combinational)
//   m_req/m_we/m_addr/m_wdata  memory request (registered)
//   m_rdata/m_ack              memory response
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);

  localparam starve_t LIMIT = starve_t'(STARVE_LIMIT);

  arb_state_t        state_q;
  starve_t           starve_q;
  starve_t           starve_d;
  logic              flush_pend_q;
  logic              m_req_q;
  logic              m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_valid_q;
  logic              d_valid_q;

  logic              d_req;
  logic              gnt_valid;
  owner_t            gnt_owner;

  assign d_req = mem_read_in | mem_write_in;

  // Data wins unless IF has already been passed over LIMIT times in a row.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_owner = OWN_I;
    if (d_req && (!if_req || (starve_q < LIMIT))) begin
      gnt_valid = 1'b1;
      gnt_owner = OWN_D;
    end else if (if_req && !if_flush) begin
      gnt_valid = 1'b1;
      gnt_owner = OWN_I;
    end
  end

  // Counter update as seen from IDLE; only counts D grants that bypass a
  // waiting fetch, saturating at LIMIT.
  always_comb begin
    starve_d = starve_q;
    if (gnt_valid && gnt_owner == OWN_D) begin
      if (!if_req)               starve_d = '0;
      else if (starve_q < LIMIT) starve_d = starve_q + starve_t'(1);
    end else if (gnt_valid) begin
      starve_d = '0;
    end else if (!if_req) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      flush_pend_q <= 1'b0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          starve_q <= starve_d;
          if (gnt_valid) begin
            m_req_q <= 1'b1;
            if (gnt_owner == OWN_D) begin
              state_q   <= BUSY_D;
              m_we_q    <= mem_write_in;
              m_addr_q  <= d_addr;
              m_wdata_q <= d_wdata;
            end else begin
              state_q  <= BUSY_I;
              m_we_q   <= 1'b0;
              m_addr_q <= if_addr;
            end
          end
        end
        BUSY_I: begin
          if (m_ack) begin
            state_q      <= IDLE;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            // A flush in the ack cycle itself also discards the response.
            if (!flush_pend_q && !if_flush) begin
              if_valid_q <= 1'b1;
              if_rdata_q <= m_rdata;
            end
          end else if (if_flush) begin
            flush_pend_q <= 1'b1;
          end
        end
        BUSY_D: begin
          if (m_ack) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            d_valid_q <= 1'b1;
            d_rdata_q <= m_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign if_valid = if_valid_q;
  assign d_rdata  = d_rdata_q;
  assign d_valid  = d_valid_q;

  assign stall_mem = d_req & ~d_valid_q;
  assign stall_if  = (if_req & ~if_valid_q) | stall_mem;

endmodule
